video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised two-profile video timing generator for the pixel-clock domain of the display pipeline. Produces the raster position, sync, data-enable and frame/line strobes consumed by sprite, framebuffer and HDMI/DVI output stages. Two complete timing profiles are compiled in; the active one is selected at run time and switches only on a frame boundary. All outputs are registered and mutually aligned, with no skew between position and sync.

## Interface
- CORDW, 12: width of `sx`/`sy`; must hold H_TOTAL-1 and V_TOTAL-1 of both profiles (elaboration-time `$error` otherwise)
- H_ACTIVE0/H_FP0/H_SYNC0/H_BP0, 1024/24/136/160: profile 0 horizontal timing in pixels
- V_ACTIVE0/V_FP0/V_SYNC0/V_BP0, 768/3/6/29: profile 0 vertical timing in lines
- H_ACTIVE1/H_FP1/H_SYNC1/H_BP1, 1024/40/104/144: profile 1 horizontal timing in pixels
- V_ACTIVE1/V_FP1/V_SYNC1/V_BP1, 600/3/6/11: profile 1 vertical timing in lines
- HS_POL, 1'b0: asserted level of `hsync`
- VS_POL, 1'b0: asserted level of `vsync`
- clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- mode_sel  in  1  requested profile (0/1), synchronous to `clk`
- sx  out  CORDW  horizontal position, 0..H_TOTAL-1
- sy  out  CORDW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  high in the active area
- line_start  out  1  one-cycle pulse at sx==0
- frame_start  out  1  one-cycle pulse at sx==0 && sy==0
- mode_active  out  1  profile currently driving the raster

## Operation
- Raster order per line: active, front porch, sync, back porch. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise, per profile.
- An internal (h,v) counter pair advances every cycle. h wraps H_TOTAL-1 -> 0 and increments v. v wraps V_TOTAL-1 -> 0 at the last pixel of the frame.
- Output registers load decoded values of the internal pair:
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vsync = VS_POL for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, asserted from h==0 of each such line, else ~VS_POL
- Profile switching:
  - `mode_sel` is sampled only in the cycle the internal pair equals (H_TOTAL-1, V_TOTAL-1) of the current profile.
  - The sampled value becomes the current profile for the next frame, starting at (0,0).
  - Changes of `mode_sel` at any other time are ignored; only the value at the boundary matters.
- Comparisons are unsigned at CORDW width. Profile constants are truncated to CORDW only after the width check.

## Timing
- Reset (reset_n low): internal pair = (0,0); current profile = 0; sx=0, sy=0, de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, mode_active=0.
- First rising edge after release: outputs show (0,0), de=1, line_start=1, frame_start=1.
- Latency: outputs lag the internal pair by exactly one cycle. All outputs belong to the same pixel.
- mode_active changes on the same edge that sx/sy show (0,0) of the first frame in the new profile.
- Frame length: profile 0 = 1344x806 = 1,083,264 cycles; profile 1 = 1312x620 = 813,440 cycles.
- Reset asserted mid-frame: immediate return to the reset values above; the profile reverts to 0.

## Configuration
- VTG_FRAME_COUNT_EN defined: adds output `frame_count [15:0]`.
  - Reset value 0.
  - Increments on the edge where frame_start is asserted, so it reads 1 during the first frame after reset.
  - Wraps 0xFFFF -> 0.
- VTG_FRAME_COUNT_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `video_timing_pkg`:
  - `timing_t` struct (h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp)
  - constants `TIMING_1024_768` and `TIMING_1024_600`
  - function returning h_total/v_total
- One sub-module, `vtg_axis`: a generic wrap counter with active/sync region decode, instantiated once for h and once for v (v advanced by the h wrap).

## Test plan
- Reset release, mode_sel=0 -> first output cycle sx=0, sy=0, de=1, frame_start=1, hsync=1, vsync=1; second cycle sx=1, frame_start=0.
- Profile 0 line scan -> de falls at sx=1024; hsync low for sx=1048..1183; line_start pulses every 1344 cycles.
- Profile 0 frame -> vsync low for sy=771..776; frame_start period exactly 1,083,264 cycles.
- mode_sel toggled 0->1 at sy=100, then 1->0 at sy=500, then 0->1 one cycle before the boundary -> profile 1 starts next frame; mode_active=1; next frame_start 813,440 cycles later.
- reset_n pulsed low at sx=500, sy=300 while on profile 1 -> outputs return to reset values asynchronously; after release the raster restarts at (0,0) with mode_active=0.
- VTG_FRAME_COUNT_EN with frame_count forced near wrap (short test profiles, e.g. 8x4 total) -> 0xFFFF followed by 0x0000 on the next frame_start.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - timing profile type, standard profiles and total helpers
package video_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } timing_t;

    localparam timing_t TIMING_1024_768 = '{
        h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
        v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
    };

    localparam timing_t TIMING_1024_600 = '{
        h_active: 1024, h_fp: 40, h_sync: 104, h_bp: 144,
        v_active: 600,  v_fp: 3,  v_sync: 6,   v_bp: 11
    };

    function automatic int unsigned h_total(timing_t t);
        return t.h_active + t.h_fp + t.h_sync + t.h_bp;
    endfunction

    function automatic int unsigned v_total(timing_t t);
        return t.v_active + t.v_fp + t.v_sync + t.v_bp;
    endfunction

endpackage

// File: rtl/vtg_axis.sv
// rtl/vtg_axis.sv - one raster axis: wrap counter with active and sync region decode
module vtg_axis #(
    parameter int CORDW = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [CORDW-1:0] last_i,
    input  logic [CORDW-1:0] active_i,
    input  logic [CORDW-1:0] sync_start_i,
    input  logic [CORDW-1:0] sync_end_i,
    output logic [CORDW-1:0] count_o,
    output logic             wrap_o,
    output logic             active_o,
    output logic             sync_o
);

    logic [CORDW-1:0] count_q, count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == last_i);
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = count_q < active_i;
    assign sync_o   = (count_q >= sync_start_i) && (count_q < sync_end_i);

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - two-profile video timing generator, profile switch on frame boundary
// Optional frame_count output enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int          CORDW     = 12,
    parameter int unsigned H_ACTIVE0 = TIMING_1024_768.h_active,
    parameter int unsigned H_FP0     = TIMING_1024_768.h_fp,
    parameter int unsigned H_SYNC0   = TIMING_1024_768.h_sync,
    parameter int unsigned H_BP0     = TIMING_1024_768.h_bp,
    parameter int unsigned V_ACTIVE0 = TIMING_1024_768.v_active,
    parameter int unsigned V_FP0     = TIMING_1024_768.v_fp,
    parameter int unsigned V_SYNC0   = TIMING_1024_768.v_sync,
    parameter int unsigned V_BP0     = TIMING_1024_768.v_bp,
    parameter int unsigned H_ACTIVE1 = TIMING_1024_600.h_active,
    parameter int unsigned H_FP1     = TIMING_1024_600.h_fp,
    parameter int unsigned H_SYNC1   = TIMING_1024_600.h_sync,
    parameter int unsigned H_BP1     = TIMING_1024_600.h_bp,
    parameter int unsigned V_ACTIVE1 = TIMING_1024_600.v_active,
    parameter int unsigned V_FP1     = TIMING_1024_600.v_fp,
    parameter int unsigned V_SYNC1   = TIMING_1024_600.v_sync,
    parameter int unsigned V_BP1     = TIMING_1024_600.v_bp,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode_sel,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic             mode_active
`ifdef VTG_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam timing_t P0 = '{
        h_active: H_ACTIVE0, h_fp: H_FP0, h_sync: H_SYNC0, h_bp: H_BP0,
        v_active: V_ACTIVE0, v_fp: V_FP0, v_sync: V_SYNC0, v_bp: V_BP0
    };
    localparam timing_t P1 = '{
        h_active: H_ACTIVE1, h_fp: H_FP1, h_sync: H_SYNC1, h_bp: H_BP1,
        v_active: V_ACTIVE1, v_fp: V_FP1, v_sync: V_SYNC1, v_bp: V_BP1
    };
    localparam longint unsigned COORD_RANGE = 64'd1 << CORDW;

    if (h_total(P0) > COORD_RANGE || v_total(P0) > COORD_RANGE ||
        h_total(P1) > COORD_RANGE || v_total(P1) > COORD_RANGE) begin : g_cordw_check
        $error("video_timing_gen: CORDW=%0d cannot hold the raster of both profiles", CORDW);
    end

    logic             mode_q, mode_d;
    timing_t          cur;
    logic [CORDW-1:0] h_last, h_act, h_ss, h_se;
    logic [CORDW-1:0] v_last, v_act, v_ss, v_se;
    logic [CORDW-1:0] h_count, v_count;
    logic             h_wrap, v_wrap, h_active, v_active, h_in_sync, v_in_sync;
    logic             at_origin;

    // Truncation to CORDW happens only here, after the width check above.
    always_comb begin
        cur    = mode_q ? P1 : P0;
        h_last = CORDW'(h_total(cur) - 1);
        h_act  = CORDW'(cur.h_active);
        h_ss   = CORDW'(cur.h_active + cur.h_fp);
        h_se   = CORDW'(cur.h_active + cur.h_fp + cur.h_sync);
        v_last = CORDW'(v_total(cur) - 1);
        v_act  = CORDW'(cur.v_active);
        v_ss   = CORDW'(cur.v_active + cur.v_fp);
        v_se   = CORDW'(cur.v_active + cur.v_fp + cur.v_sync);
    end

    vtg_axis #(.CORDW(CORDW)) u_h_axis (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .en_i        (1'b1),
        .last_i      (h_last),
        .active_i    (h_act),
        .sync_start_i(h_ss),
        .sync_end_i  (h_se),
        .count_o     (h_count),
        .wrap_o      (h_wrap),
        .active_o    (h_active),
        .sync_o      (h_in_sync)
    );

    vtg_axis #(.CORDW(CORDW)) u_v_axis (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .en_i        (h_wrap),
        .last_i      (v_last),
        .active_i    (v_act),
        .sync_start_i(v_ss),
        .sync_end_i  (v_se),
        .count_o     (v_count),
        .wrap_o      (v_wrap),
        .active_o    (v_active),
        .sync_o      (v_in_sync)
    );

    // v only wraps while h wraps, so v_wrap marks the last pixel of the frame.
    assign mode_d    = v_wrap ? mode_sel : mode_q;
    assign at_origin = (h_count == '0) && (v_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q        <= 1'b0;
            sx            <= '0;
            sy            <= '0;
            de            <= 1'b0;
            hsync         <= ~HS_POL;
            vsync         <= ~VS_POL;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            mode_active   <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            sx            <= h_count;
            sy            <= v_count;
            de            <= h_active && v_active;
            hsync         <= h_in_sync ? HS_POL : ~HS_POL;
            vsync         <= v_in_sync ? VS_POL : ~VS_POL;
            line_start    <= h_count == '0;
            frame_start   <= at_origin;
            mode_active   <= mode_q;
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    assign frame_count_d = at_origin ? frame_count_q + 16'd1 : frame_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule
